dma_sched: RTL

Two-requester command scheduler in front of the DMA engine. It accepts transfer descriptors (source, destination, length) from two requesters, arbitrates between them round-robin, and drives the DMA enable/config lines (DMAEN, DMASRC, DMADST, DMALEN). It holds DMAEN until the engine signals completion on DMA_interrupt, then returns a tagged completion to the requester that owned the transfer. It sits between the CPU/accelerator command sources and the DMA engine's configuration inputs.

---
 rtl/dma_sched_if.sv | 37 +++
 rtl/dma_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dma_sched_if.sv
// Descriptor, DMA-engine config and completion signals of dma_sched.
// slave is the scheduler side; master is the requester/engine side.
interface dma_sched_if;
  logic        req_valid0;
  logic        req_valid1;
  logic        req_ready0;
  logic        req_ready1;
  logic [31:0] req_src0;
  logic [31:0] req_src1;
  logic [31:0] req_dst0;
  logic [31:0] req_dst1;
  logic [31:0] req_len0;
  logic [31:0] req_len1;
  logic        DMAEN;
  logic [31:0] DMASRC;
  logic [31:0] DMADST;
  logic [31:0] DMALEN;
  logic        DMA_interrupt;
  logic        cpl_valid;
  logic        cpl_id;
  logic        cpl_err;
  logic        busy;

  modport slave (
    input  req_valid0, req_valid1, req_src0, req_src1, req_dst0, req_dst1,
           req_len0, req_len1, DMA_interrupt,
    output req_ready0, req_ready1, DMAEN, DMASRC, DMADST, DMALEN,
           cpl_valid, cpl_id, cpl_err, busy
  );

  modport master (
    output req_valid0, req_valid1, req_src0, req_src1, req_dst0, req_dst1,
           req_len0, req_len1, DMA_interrupt,
    input  req_ready0, req_ready1, DMAEN, DMASRC, DMADST, DMALEN,
           cpl_valid, cpl_id, cpl_err, busy
  );
endinterface

// File: rtl/dma_sched.sv
// Two-requester round-robin command scheduler driving the DMA engine config lines.
// Optional RUN watchdog compiled in with DMA_SCHED_TIMEOUT_EN (limit TIMEOUT_CYCLES).
//   state | meaning
//   IDLE  | waiting for a descriptor; grants only while DMA_interrupt is low
//   RUN   | DMAEN high, waiting for the engine done level
//   DRAIN | DMAEN low, waiting for the done level to clear
//   CPL   | one-cycle tagged completion to the owning requester
module dma_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  dma_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CPL} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;

  logic        grant0, grant1;
  logic        accept;
  logic [31:0] acc_src, acc_dst, acc_len;
  logic        timeout_hit;

  // last_q holds the index of the previous grant; on contention the other one wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !bus.DMA_interrupt) begin
      if (bus.req_valid0 && bus.req_valid1) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = bus.req_valid0;
        grant1 = bus.req_valid1;
      end
    end
  end

  assign accept  = grant0 | grant1;
  assign acc_src = grant1 ? bus.req_src1 : bus.req_src0;
  assign acc_dst = grant1 ? bus.req_dst1 : bus.req_dst0;
  assign acc_len = grant1 ? bus.req_len1 : bus.req_len0;

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == RUN) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  assign timeout_hit = (state_q == RUN) && (tmo_cnt_d == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    err_d   = err_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d  = acc_src;
          dst_d  = acc_dst;
          len_d  = acc_len;
          id_d   = grant1;
          last_d = grant1;
          // a zero-length descriptor never reaches the engine
          if (acc_len == 32'd0) begin
            err_d   = 1'b1;
            state_d = CPL;
          end else begin
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.DMA_interrupt) begin
          err_d   = 1'b0;
          state_d = DRAIN;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.DMA_interrupt) state_d = CPL;
      end
      CPL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      err_q   <= err_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
    end
  end

  assign bus.req_ready0 = grant0;
  assign bus.req_ready1 = grant1;
  assign bus.DMAEN      = (state_q == RUN);
  assign bus.DMASRC     = src_q;
  assign bus.DMADST     = dst_q;
  assign bus.DMALEN     = len_q;
  assign bus.cpl_valid  = (state_q == CPL);
  assign bus.cpl_id     = id_q;
  assign bus.cpl_err    = err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
